// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: framebuffer scan sequencer for a HUB75 row driver.
// Walks rows and BCM bit-planes, fetches the top/bottom pixel pair per column,
// presents one plane of RGB, and holds each latched plane for BASE_TICKS<<plane.
//
// Handshake with the driver: out_INIT is a one-cycle request issued only while
// in_WAITING=1. in_ITER pulses mean "column consumed". A transfer is complete
// when in_WAITING returns high in DRAIN. in_ITER is ignored outside SHIFT.
module hub75_scan_ctrl #(
    parameter int COLS       = 64,
    parameter int ROWS_HALF  = 32,
    parameter int PLANES     = 8,
    parameter int BASE_TICKS = 16,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS_HALF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_EN,
    input  logic                  in_WAITING,
    input  logic                  in_ITER,
    output logic                  out_INIT,
    output logic [2:0]            out_RGB0,
    output logic [2:0]            out_RGB1,
    output logic [RW-1:0]         out_ROW,
    output logic [RW+CW-1:0]      out_RADDR,
    input  logic [3*PLANES-1:0]   in_PIX0,
    input  logic [3*PLANES-1:0]   in_PIX1,
    output logic                  out_FRAME,
    output logic                  out_BUSY,
    output logic [2:0]            out_DBG_STATE
);

    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int HW = $clog2(BASE_TICKS) + PLANES;
    localparam logic [HW-1:0] BASE = HW'(BASE_TICKS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]      r_state;
    logic            r_fcnt;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [PW-1:0]   r_plane;
    logic [HW-1:0]   r_hold;
    logic [RW-1:0]   r_row_out;
    logic [RW+CW-1:0] r_raddr;
    logic            r_iss1;
    logic            r_iss2;
    logic [2:0]      r_rgb0;
    logic [2:0]      r_rgb1;

    logic            w_init;
    logic            w_drain_done;
    logic            w_plane_last;
    logic            w_row_last;
    logic [RW-1:0]   w_next_row;
    logic [PW-1:0]   w_next_plane;
    logic [HW-1:0]   w_hold_load;
    logic [PLANES-1:0] w_r0, w_g0, w_b0, w_r1, w_g1, w_b1;

    assign w_init       = (r_state == S_HOLD) && (r_hold == '0) && in_WAITING;
    assign w_drain_done = (r_state == S_DRAIN) && in_WAITING;
    assign w_plane_last = (r_plane == PW'(PLANES - 1));
    assign w_row_last   = (r_row == RW'(ROWS_HALF - 1));
    assign w_next_plane = w_plane_last ? '0 : r_plane + 1'b1;
    assign w_next_row   = w_plane_last ? (w_row_last ? '0 : r_row + 1'b1) : r_row;
    assign w_hold_load  = BASE << r_plane;

    assign w_r0 = in_PIX0[3*PLANES-1:2*PLANES];
    assign w_g0 = in_PIX0[2*PLANES-1:PLANES];
    assign w_b0 = in_PIX0[PLANES-1:0];
    assign w_r1 = in_PIX1[3*PLANES-1:2*PLANES];
    assign w_g1 = in_PIX1[2*PLANES-1:PLANES];
    assign w_b1 = in_PIX1[PLANES-1:0];

    assign out_INIT      = w_init;
    assign out_FRAME     = w_drain_done && w_plane_last && w_row_last;
    assign out_BUSY      = (r_state != S_IDLE);
    assign out_RGB0      = r_rgb0;
    assign out_RGB1      = r_rgb1;
    assign out_ROW       = r_row_out;
    assign out_RADDR     = r_raddr;
    assign out_DBG_STATE = r_state;

    // Scan FSM: address issue, column walk, plane/row advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_fcnt    <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
            r_plane   <= '0;
            r_row_out <= '0;
            r_raddr   <= '0;
            r_iss1    <= 1'b0;
        end else begin
            r_iss1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_EN) begin
                        r_state <= S_FETCH;
                        r_fcnt  <= 1'b0;
                        r_col   <= '0;
                        r_raddr <= {r_row, {CW{1'b0}}};
                        r_iss1  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (r_fcnt) r_state <= S_HOLD;
                    else        r_fcnt  <= 1'b1;
                end
                S_HOLD: begin
                    if (w_init) begin
                        r_row_out <= r_row;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (in_ITER) begin
                        if (r_col == CW'(COLS - 1)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_col   <= r_col + 1'b1;
                            r_raddr <= {r_row, r_col + 1'b1};
                            r_iss1  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (in_WAITING) begin
                        r_plane <= w_next_plane;
                        r_row   <= w_next_row;
                        r_col   <= '0;
                        r_fcnt  <= 1'b0;
                        r_raddr <= {w_next_row, {CW{1'b0}}};
                        r_iss1  <= in_EN;
                        r_state <= in_EN ? S_FETCH : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // BCM display timer: loaded at transfer end, counts down in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_drain_done) begin
            r_hold <= w_hold_load;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
        end
    end

    // Read pipeline: data returns one cycle after the address, registered the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss2 <= 1'b0;
            r_rgb0 <= '0;
            r_rgb1 <= '0;
        end else begin
            r_iss2 <= r_iss1;
            if (r_iss2) begin
                r_rgb0 <= {w_r0[r_plane], w_g0[r_plane], w_b0[r_plane]};
                r_rgb1 <= {w_r1[r_plane], w_g1[r_plane], w_b1[r_plane]};
            end
        end
    end

endmodule
